// File: rtl/hazard_ctrl_if.sv
// Hazard controller port bundle: ID-stage decode info and branch
// resolution in, stall/flush/forward controls and event counters out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic             id_RegisterWrite;
    logic             id_ResultSourceSelect;
    logic             ex_BranchTaken;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd,
        output id_RegisterWrite, id_ResultSourceSelect,
        output ex_BranchTaken,
        input  StallF, StallD, FlushD, FlushE,
        input  ForwardAE, ForwardBE,
        input  stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd,
        input  id_RegisterWrite, id_ResultSourceSelect,
        input  ex_BranchTaken,
        output StallF, StallD, FlushD, FlushE,
        output ForwardAE, ForwardBE,
        output stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: register-use tag pipeline,
// EX operand forwarding, load-use stalls and taken-branch flushes.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
    } ex_tag_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
    } tag_t;

    ex_tag_t          ex_q;
    tag_t             mem_q;
    tag_t             wb_q;
    logic             lu;
    logic             br;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input tag_t       m,
        input tag_t       w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (m.v && m.rw && m.rd != 5'd0 && m.rd == rs)
            sel = 2'b10;
        else if (w.v && w.rw && w.rd != 5'd0 && w.rd == rs)
            sel = 2'b01;
        return sel;
    endfunction

    always_comb begin
        lu = hz.id_valid && ex_q.v && ex_q.ld
          && ex_q.rd != 5'd0
          && (ex_q.rd == hz.id_rs1 || ex_q.rd == hz.id_rs2);
    end

    // Branch input is masked while in reset so no flush leaks out
    assign br    = hz.ex_BranchTaken & rst_n;
    assign stall = lu & ~br;

    assign hz.StallF      = stall;
    assign hz.StallD      = stall;
    assign hz.FlushD      = br;
    assign hz.FlushE      = br | lu;
    assign hz.ForwardAE   = fwd_sel(ex_q.rs1, mem_q, wb_q);
    assign hz.ForwardBE   = fwd_sel(ex_q.rs2, mem_q, wb_q);
    assign hz.stall_count = stall_cnt;
    assign hz.flush_count = flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= '{v: ex_q.v, rd: ex_q.rd, rw: ex_q.rw};
            // A bubble carries all-zero fields, so it can never forward
            if (lu || br)
                ex_q <= '0;
            else
                ex_q <= '{v:   hz.id_valid,
                          rs1: hz.id_rs1,
                          rs2: hz.id_rs2,
                          rd:  hz.id_rd,
                          rw:  hz.id_RegisterWrite,
                          ld:  hz.id_ResultSourceSelect};
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (br && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core. It tracks register-use tags alongside the ID→EX→MEM→WB flow and drives the ALU operand forwarding selects. It also generates load-use stalls and taken-branch flushes. It sits beside the decode stage, consumes the main decoder's control outputs for the instruction in ID, and steers the fetch/decode pipeline registers and the EX operand muxes.

## Interface

Parameters:
- CNT_W, 16, width of the saturating stall and flush event counters

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  a real instruction occupies ID (0 = bubble)
- id_rs1  in  5  source register 1 of the ID instruction
- id_rs2  in  5  source register 2 of the ID instruction
- id_rd  in  5  destination register of the ID instruction
- id_RegisterWrite  in  1  decoder RegisterWrite for the ID instruction
- id_ResultSourceSelect  in  1  decoder ResultSourceSelect; 1 = load
- ex_BranchTaken  in  1  branch in EX resolved taken this cycle
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- FlushD  out  1  clear IF/ID register
- FlushE  out  1  clear ID/EX register (insert bubble)
- ForwardAE  out  2  EX operand A select: 00 regfile, 01 WB result, 10 MEM ALU result
- ForwardBE  out  2  EX operand B select, same encoding
- stall_count  out  CNT_W  load-use stall cycles, saturating
- flush_count  out  CNT_W  taken-branch flush events, saturating

## Operation

- Internal tag pipeline:
  - EX tag: {v, rs1, rs2, rd, rw, ld}
  - MEM tag: {v, rd, rw}
  - WB tag: {v, rd, rw}
- Each rising edge: WB←MEM, MEM←EX, and EX←ID fields (v = id_valid), except where a stall or flush inserts a bubble.
- On load-use or flush, the EX tag loads a bubble (v = 0). MEM and WB still advance.
- Load-use hazard (`lu`) = id_valid & EX.v & EX.ld & EX.rd≠0 & (EX.rd==id_rs1 | EX.rd==id_rs2).
- Stall outputs: StallF = StallD = lu & ~ex_BranchTaken.
- Flush outputs:
  - FlushD = ex_BranchTaken.
  - FlushE = ex_BranchTaken | lu.
- ForwardAE:
  - 10 if MEM.v & MEM.rw & MEM.rd≠0 & MEM.rd==EX.rs1.
  - Otherwise 01 if WB.v & WB.rw & WB.rd≠0 & WB.rd==EX.rs1.
  - Otherwise 00.
- ForwardBE: identical to ForwardAE, using EX.rs2.
- MEM has priority over WB. x0 is never forwarded and never triggers a stall.
- A bubble tag (v = 0) never matches, regardless of its field contents.
- No decode-stage forwarding. The register file is write-first, so a WB write and an ID read of the same register in one cycle return the new value.
- Counters:
  - stall_count +1 on each edge where StallD = 1.
  - flush_count +1 on each edge where ex_BranchTaken = 1.
  - Both hold at 2^CNT_W−1.
- Simultaneous taken branch and load-use: the branch wins. StallF/StallD = 0, FlushD = FlushE = 1. stall_count does not increment; flush_count does.

## Timing

- Reset (rst_n low, asynchronous): all tag v bits = 0 and both counters = 0.
- Outputs during and immediately after reset: StallF = StallD = FlushD = 0, ForwardAE = ForwardBE = 00, counters 0. FlushE and StallF/StallD follow their equations, with EX.v = 0 so lu = 0.
- Reset mid-stall: stall deasserts as soon as rst_n falls; no tag survives.
- Stall, flush and forward outputs are combinational from the current tags and ID inputs. They are valid in the same cycle, with zero latency.
- Load-use stall lasts exactly one cycle per hazard. The next cycle, the load is in MEM and the dependent instruction is still in ID.
- The cycle after that, the dependent instruction is in EX with the load in WB, giving Forward*E = 01.
- Taken-branch flush lasts exactly one cycle per ex_BranchTaken pulse.
- Counters update on the edge that ends the event cycle; the new value is visible the following cycle.

## Test plan

- Reset: hold rst_n = 0 with random inputs → all Stall/Flush = 0, Forward*E = 00, counters 0. Release → same until a hazard is presented.
- ALU→ALU: add x5 followed by add x6,x5,x1 → ForwardAE = 10, ForwardBE = 00 while add x6 is in EX. With one unrelated instruction between them → ForwardAE = 01.
- Load-use: lw x5 followed by add x7,x5,x5 → StallF = StallD = FlushE = 1 for exactly one cycle, then ForwardAE = ForwardBE = 01. stall_count = 1.
- Taken branch: ex_BranchTaken pulsed one cycle → FlushD = FlushE = 1 that cycle only. The next EX tag is a bubble (no forwarding from it). flush_count = 1.
- x0 and priority:
  - lw x0 then add x1,x0,x0 → no stall, Forward = 00.
  - Load-use coincident with ex_BranchTaken → StallD = 0, FlushD = 1, stall_count unchanged.
- Saturation and reset: CNT_W = 4, 20 load-use hazards → stall_count = 15. Drop rst_n mid-stall → StallD = 0 immediately, counters = 0.
